// File: rtl/calc_pkg.sv
// Shared key codes, one-hot operator encodings and FSM states for the keypad calculator.
// Chained operators are enabled by defining CALC_CHAIN_OPS_EN (see calc_sequencer).
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        WAIT,
        SHOW,
        ERR,
        DRAIN
    } calc_state_t;

    // Only meaningful for operator key codes; anything else falls back to add.
    function automatic logic [3:0] opOneHot(input logic [3:0] code);
        logic [3:0] op;
        case (code)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal entry accumulator: acc = acc*10 + digit, limited to DIGITS digits per operand.
// o_accNext exposes the value the register takes this edge so the display can follow it.
module calc_digit_acc #(
    parameter int W      = 16,
    parameter int DIGITS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_digitEn,
    input  logic [3:0]   i_digit,
    output logic [W-1:0] o_acc,
    output logic [W-1:0] o_accNext
);

    localparam int CW = $clog2(DIGITS + 1);

    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_count;
    logic          w_accept;

    // Digits beyond the operand width are silently dropped.
    assign w_accept  = i_digitEn && (r_count < CW'(DIGITS));
    assign o_accNext = i_clear  ? '0 :
                       w_accept ? (r_acc * W'(10)) + W'(i_digit) :
                                  r_acc;
    assign o_acc     = r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= o_accNext;
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM: operand entry, operator latch, ALU start/done handshake with timeout.
// Define CALC_CHAIN_OPS_EN to make an operator key in ENTER_B act as an implicit equals.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W           = 16,
    parameter int DIGITS      = 4,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_ovf,
    output logic         alu_start,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [W-1:0] display_val,
    output logic         error,
    output logic         busy
);

`ifdef CALC_CHAIN_OPS_EN
    localparam bit CHAIN_OPS = 1'b1;
`else
    localparam bit CHAIN_OPS = 1'b0;
`endif

    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    calc_state_t   r_state;
    logic          r_aluStart;
    logic [3:0]    r_aluOp;
    logic [W-1:0]  r_aluA;
    logic [W-1:0]  r_aluB;
    logic [W-1:0]  r_display;
    logic          r_error;
    logic [TW-1:0] r_timer;
    logic          r_chain;
    logic [3:0]    r_pendOp;

    logic          w_isDigit;
    logic          w_isOp;
    logic          w_isEquals;
    logic          w_isClear;
    logic          w_entry;
    logic          w_digitEn;
    logic          w_accClear;
    logic          w_timeout;
    logic [3:0]    w_keyOp;
    logic [W-1:0]  w_acc;
    logic [W-1:0]  w_accNext;

    assign w_isDigit  = key_code < 4'd10;
    assign w_isOp     = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    assign w_isEquals = key_code == KEY_EQ;
    assign w_isClear  = key_code == KEY_CLR;
    assign w_keyOp    = opOneHot(key_code);
    assign w_timeout  = r_timer == TW'(ALU_TIMEOUT - 1);
    assign w_entry    = (r_state == ENTER_A) || (r_state == ENTER_B) || (r_state == SHOW);

    // acc is only ever non-zero in the entry states, so clears elsewhere are not needed.
    assign w_digitEn  = key_valid && w_entry && w_isDigit;
    assign w_accClear = key_valid && w_entry &&
                        (w_isClear ||
                         (w_isOp && ((r_state != ENTER_B) || CHAIN_OPS)) ||
                         (w_isEquals && (r_state == ENTER_B)));

    calc_digit_acc #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_digitAcc (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accClear),
        .i_digitEn (w_digitEn),
        .i_digit   (key_code),
        .o_acc     (w_acc),
        .o_accNext (w_accNext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ENTER_A;
            r_aluStart <= 1'b0;
            r_aluOp    <= '0;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_display  <= '0;
            r_error    <= 1'b0;
            r_timer    <= '0;
            r_chain    <= 1'b0;
            r_pendOp   <= '0;
        end else begin
            r_aluStart <= 1'b0;
            case (r_state)
                ENTER_A, ENTER_B, SHOW: begin
                    if (key_valid) begin
                        if (w_isClear) begin
                            r_state   <= ENTER_A;
                            r_aluOp   <= '0;
                            r_aluA    <= '0;
                            r_aluB    <= '0;
                            r_display <= '0;
                            r_chain   <= 1'b0;
                        end else if (w_isDigit) begin
                            r_display <= w_accNext;
                            if (r_state == SHOW) begin
                                r_state <= ENTER_A;
                            end
                        end else if (w_isOp) begin
                            if (r_state == ENTER_B) begin
                                if (CHAIN_OPS) begin
                                    r_aluB   <= w_acc;
                                    r_pendOp <= w_keyOp;
                                    r_chain  <= 1'b1;
                                    r_state  <= EXEC;
                                end else begin
                                    r_aluOp <= w_keyOp;
                                end
                            end else begin
                                r_aluA  <= (r_state == SHOW) ? r_display : w_acc;
                                r_aluOp <= w_keyOp;
                                r_state <= ENTER_B;
                            end
                        end else if (w_isEquals && (r_state == ENTER_B)) begin
                            r_aluB  <= w_acc;
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (key_valid && w_isClear) begin
                        r_state   <= ENTER_A;
                        r_aluOp   <= '0;
                        r_aluA    <= '0;
                        r_aluB    <= '0;
                        r_display <= '0;
                        r_chain   <= 1'b0;
                    end else if ((r_aluOp == OP_DIV) && (r_aluB == '0)) begin
                        r_state   <= ERR;
                        r_error   <= 1'b1;
                        r_display <= '0;
                        r_chain   <= 1'b0;
                    end else begin
                        r_aluStart <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (alu_done && !alu_ovf) begin
                        r_display <= alu_result;
                        if (r_chain) begin
                            r_aluA  <= alu_result;
                            r_aluOp <= r_pendOp;
                            r_chain <= 1'b0;
                            r_state <= ENTER_B;
                        end else begin
                            r_state <= SHOW;
                        end
                    end else if (alu_done || w_timeout) begin
                        r_state   <= ERR;
                        r_error   <= 1'b1;
                        r_display <= '0;
                        r_chain   <= 1'b0;
                    end else if (key_valid && w_isClear) begin
                        r_state   <= DRAIN;
                        r_display <= '0;
                        r_chain   <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Operands stay driven until the in-flight ALU operation finishes.
                    r_timer <= r_timer + 1'b1;
                    if (alu_done || w_timeout) begin
                        r_state <= ENTER_A;
                        r_aluOp <= '0;
                        r_aluA  <= '0;
                        r_aluB  <= '0;
                    end
                end
                ERR: begin
                    if (key_valid && w_isClear) begin
                        r_state   <= ENTER_A;
                        r_error   <= 1'b0;
                        r_aluOp   <= '0;
                        r_aluA    <= '0;
                        r_aluB    <= '0;
                        r_display <= '0;
                    end
                end
                default: r_state <= ENTER_A;
            endcase
        end
    end

    assign alu_start   = r_aluStart;
    assign alu_op      = r_aluOp;
    assign alu_a       = r_aluA;
    assign alu_b       = r_aluB;
    assign display_val = r_display;
    assign error       = r_error;
    assign busy        = (r_state == EXEC) || (r_state == WAIT) || (r_state == DRAIN);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: expected ALU launches go into a scoreboard queue
// that a monitor drains on every alu_start; display/error/busy are checked after each key sequence.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int W           = 16;
    localparam int DIGITS      = 4;
    localparam int ALU_TIMEOUT = 64;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } launch_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         alu_done;
    logic [W-1:0] alu_result;
    logic         alu_ovf;
    logic         alu_start;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] display_val;
    logic         error;
    logic         busy;

    launch_t      expQ[$];
    launch_t      expLaunch;
    int           nChecks = 0;
    int           nPass   = 0;
    int           aluLatency = 3;
    logic [W-1:0] aluResult  = '0;
    logic         aluOvfCfg  = 1'b0;
    bit           aluSilent  = 1'b0;
    int           waitCount;

    calc_sequencer #(
        .W           (W),
        .DIGITS      (DIGITS),
        .ALU_TIMEOUT (ALU_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .alu_ovf     (alu_ovf),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .display_val (display_val),
        .error       (error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic expectLaunch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        launch_t e;
        e.op = op;
        e.a  = a;
        e.b  = b;
        expQ.push_back(e);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    task automatic waitStart(input string name);
        int n = 0;
        while (!alu_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(alu_start), 32'd1);
    endtask

    // Scoreboard monitor: every launch must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && alu_start) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_alu_start", 32'd1, 32'd0);
            end else begin
                expLaunch = expQ.pop_front();
                checkOutput("launch_op", 32'(alu_op), 32'(expLaunch.op));
                checkOutput("launch_a", 32'(alu_a), 32'(expLaunch.a));
                checkOutput("launch_b", 32'(alu_b), 32'(expLaunch.b));
            end
        end
    end

    // Behavioural ALU: answers aluLatency cycles after a launch unless told to stay silent.
    initial begin
        alu_done   = 1'b0;
        alu_result = '0;
        alu_ovf    = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_start && !aluSilent) begin
                repeat (aluLatency) @(negedge clk);
                alu_done   = 1'b1;
                alu_result = aluResult;
                alu_ovf    = aluOvfCfg;
                @(negedge clk);
                alu_done   = 1'b0;
                alu_ovf    = 1'b0;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_display", 32'(display_val), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_alu_op", 32'(alu_op), 32'd0);
        checkOutput("reset_alu_start", 32'(alu_start), 32'd0);

        // 12 + 3 = 15
        aluLatency = 3;
        aluResult  = 16'd15;
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        checkOutput("entry_display_12", 32'(display_val), 32'd12);
        applyStimulus(KEY_ADD);
        applyStimulus(4'd3);
        expectLaunch(OP_ADD, 16'd12, 16'd3);
        applyStimulus(KEY_EQ);
        checkOutput("busy_after_equals", 32'(busy), 32'd1);
        waitIdle("add_idle");
        checkOutput("add_display", 32'(display_val), 32'd15);
        checkOutput("add_error", 32'(error), 32'd0);

        // Equals in SHOW does nothing; operator in SHOW reuses the result as A.
        applyStimulus(KEY_EQ);
        @(negedge clk);
        checkOutput("show_equals_busy", 32'(busy), 32'd0);
        checkOutput("show_equals_display", 32'(display_val), 32'd15);
        aluResult = 16'd16;
        applyStimulus(KEY_ADD);
        applyStimulus(4'd1);
        expectLaunch(OP_ADD, 16'd15, 16'd1);
        applyStimulus(KEY_EQ);
        waitIdle("show_op_idle");
        checkOutput("show_op_display", 32'(display_val), 32'd16);
        applyStimulus(4'd7);
        checkOutput("show_digit_new_entry", 32'(display_val), 32'd7);

        // Fifth digit is ignored.
        applyStimulus(KEY_CLR);
        checkOutput("clear_display", 32'(display_val), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(4'd9);
        checkOutput("five_digits_display", 32'(display_val), 32'd9999);

        // Divide by zero: no launch, sticky error until clear.
        applyStimulus(KEY_CLR);
        applyStimulus(4'd8);
        applyStimulus(KEY_DIV);
        applyStimulus(4'd0);
        applyStimulus(KEY_EQ);
        repeat (3) @(negedge clk);
        checkOutput("div0_error", 32'(error), 32'd1);
        checkOutput("div0_display", 32'(display_val), 32'd0);
        checkOutput("div0_busy", 32'(busy), 32'd0);
        applyStimulus(4'd5);
        checkOutput("err_ignores_digit", 32'(error), 32'd1);
        applyStimulus(KEY_CLR);
        checkOutput("err_clear_error", 32'(error), 32'd0);
        checkOutput("err_clear_display", 32'(display_val), 32'd0);

        // Silent ALU: error exactly ALU_TIMEOUT cycles after the launch.
        aluSilent = 1'b1;
        applyStimulus(4'd5);
        applyStimulus(KEY_MUL);
        applyStimulus(4'd2);
        expectLaunch(OP_MUL, 16'd5, 16'd2);
        applyStimulus(KEY_EQ);
        waitStart("timeout_start_seen");
        waitCount = 0;
        while (!error && waitCount < 200) begin
            @(negedge clk);
            waitCount++;
        end
        checkOutput("timeout_cycles", 32'(waitCount), 32'(ALU_TIMEOUT));
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        aluSilent = 1'b0;
        applyStimulus(KEY_CLR);
        checkOutput("timeout_clear_error", 32'(error), 32'd0);

        // ALU overflow goes to ERR.
        aluOvfCfg = 1'b1;
        aluResult = 16'd1234;
        applyStimulus(4'd3);
        applyStimulus(KEY_SUB);
        applyStimulus(4'd5);
        expectLaunch(OP_SUB, 16'd3, 16'd5);
        applyStimulus(KEY_EQ);
        waitIdle("ovf_idle");
        checkOutput("ovf_error", 32'(error), 32'd1);
        checkOutput("ovf_display", 32'(display_val), 32'd0);
        aluOvfCfg = 1'b0;
        applyStimulus(KEY_CLR);

        // Clear during WAIT drains the late result.
        aluLatency = 10;
        aluResult  = 16'd77;
        applyStimulus(4'd1);
        applyStimulus(KEY_SUB);
        applyStimulus(4'd1);
        expectLaunch(OP_SUB, 16'd1, 16'd1);
        applyStimulus(KEY_EQ);
        waitStart("drain_start_seen");
        applyStimulus(KEY_CLR);
        checkOutput("drain_busy", 32'(busy), 32'd1);
        checkOutput("drain_display", 32'(display_val), 32'd0);
        waitIdle("drain_idle");
        checkOutput("drain_display_after_done", 32'(display_val), 32'd0);
        checkOutput("drain_error", 32'(error), 32'd0);
        applyStimulus(4'd4);
        checkOutput("drain_back_to_entry", 32'(display_val), 32'd4);
        aluLatency = 3;

        // Operator with no digits uses A = 0.
        applyStimulus(KEY_CLR);
        aluResult = 16'd4;
        applyStimulus(KEY_ADD);
        applyStimulus(4'd4);
        expectLaunch(OP_ADD, 16'd0, 16'd4);
        applyStimulus(KEY_EQ);
        waitIdle("no_digit_a_idle");
        checkOutput("no_digit_a_display", 32'(display_val), 32'd4);

        applyStimulus(KEY_CLR);
`ifdef CALC_CHAIN_OPS_EN
        // 2 + 3 * 4 = evaluates left to right: (2+3)*4.
        aluResult = 16'd5;
        applyStimulus(4'd2);
        applyStimulus(KEY_ADD);
        applyStimulus(4'd3);
        expectLaunch(OP_ADD, 16'd2, 16'd3);
        applyStimulus(KEY_MUL);
        waitIdle("chain_first_idle");
        checkOutput("chain_intermediate_display", 32'(display_val), 32'd5);
        checkOutput("chain_pending_op", 32'(alu_op), 32'(OP_MUL));
        aluResult = 16'd20;
        applyStimulus(4'd4);
        expectLaunch(OP_MUL, 16'd5, 16'd4);
        applyStimulus(KEY_EQ);
        waitIdle("chain_second_idle");
        checkOutput("chain_display", 32'(display_val), 32'd20);
`else
        // A second operator before any B digit just replaces the pending one.
        aluResult = 16'd8;
        applyStimulus(4'd2);
        applyStimulus(KEY_ADD);
        applyStimulus(KEY_MUL);
        checkOutput("replace_op_busy", 32'(busy), 32'd0);
        applyStimulus(4'd4);
        expectLaunch(OP_MUL, 16'd2, 16'd4);
        applyStimulus(KEY_EQ);
        waitIdle("replace_op_idle");
        checkOutput("replace_op_display", 32'(display_val), 32'd8);
`endif

        repeat (5) @(negedge clk);
        checkOutput("launch_queue_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
